mem_port_arbiter: RTL

//  Shares the single 16-bit synchronous memory port between two requesters:

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single synchronous memory port.
// Round-robin with a bounded burst lock; read data returns one cycle after grant.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic                  a_lock_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic                  a_gnt_o,
    output logic                  a_rvalid_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic                  b_lock_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic                  b_gnt_o,
    output logic                  b_rvalid_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_value_o,
    input  logic [DATA_WIDTH-1:0] mem_value_i,
    output logic                  mem_enable_o,
    output logic                  mem_wr_en_o,
    output logic                  mem_rd_en_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    port_t            own_q;
    port_t            rsel_q;
    port_t            winner;
    logic             act_q;
    logic             rv_q;
    logic [CNT_W-1:0] cnt_q;
    logic             grant;
    logic             own_lock;
    logic             sel_we;

    always_comb begin
        own_lock = (own_q == PORT_A) ? a_lock_i : b_lock_i;
        // Gating with rst_i keeps every strobe low for the whole reset interval.
        grant    = rst_i && (a_req_i || b_req_i);
        winner   = PORT_A;
        if (a_req_i && b_req_i) begin
            if (own_lock && act_q && (cnt_q < CNT_MAX))
                winner = own_q;
            else
                winner = (own_q == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req_i) begin
            winner = PORT_B;
        end
        sel_we = (winner == PORT_A) ? a_we_i : b_we_i;
    end

    always_comb begin
        a_gnt_o      = grant && (winner == PORT_A);
        b_gnt_o      = grant && (winner == PORT_B);
        mem_enable_o = grant;
        mem_wr_en_o  = grant && sel_we;
        mem_rd_en_o  = grant && !sel_we;
        mem_addr_o   = '0;
        mem_value_o  = '0;
        if (grant) begin
            mem_addr_o  = (winner == PORT_A) ? a_addr_i  : b_addr_i;
            mem_value_o = (winner == PORT_A) ? a_wdata_i : b_wdata_i;
        end
    end

    assign a_rvalid_o = rv_q && (rsel_q == PORT_A);
    assign b_rvalid_o = rv_q && (rsel_q == PORT_B);
    assign a_rdata_o  = mem_value_i;
    assign b_rdata_o  = mem_value_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            own_q  <= PORT_B;
            act_q  <= 1'b0;
            cnt_q  <= '0;
            rv_q   <= 1'b0;
            rsel_q <= PORT_A;
        end else begin
            rv_q   <= grant && !sel_we;
            rsel_q <= winner;
            if (grant) begin
                if (act_q && (winner == own_q))
                    cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                else
                    cnt_q <= '0;
                own_q <= winner;
                act_q <= 1'b1;
            end else begin
                act_q <= 1'b0;
                cnt_q <= '0;
            end
        end
    end

    a_gnt_exclusive: assert property (@(posedge clk_i) disable iff (!rst_i) !(a_gnt_o && b_gnt_o));

endmodule
